// File: rtl/bus_pkg.sv
// Shared bus constants for the bus multiplexer family.
// Default channel width and channel count used by bus_mux_arb.
package bus_pkg;

    localparam int BUS_WIDTH = 8;
    localparam int BUS_NCH   = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first valid channel after 'last', modulo NCH.
// Ports: valid[NCH], last[SW] in; found, idx[SW] out. Purely combinational.
module rr_pick #(
    parameter int NCH = 4,
    parameter int SW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] valid,
    input  logic [SW-1:0]  last,
    output logic           found,
    output logic [SW-1:0]  idx
);

    logic [SW:0]      start;
    logic [2*NCH-1:0] dbl;
    logic [NCH-1:0]   rot;
    logic [SW-1:0]    enc;
    logic [SW:0]      sum;

    // Rotate so the search origin lands on bit 0, take the lowest set
    // bit, then add the origin back to recover the channel index.
    always_comb begin
        start = (SW+1)'((int'(last) + 1) % NCH);
        dbl   = {valid, valid};
        rot   = NCH'(dbl >> start);
        found = 1'b0;
        enc   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                enc   = SW'(k);
            end
        end
        sum = (SW+1)'(enc) + start;
        if (sum >= (SW+1)'(NCH)) begin
            sum = sum - (SW+1)'(NCH);
        end
        idx = sum[SW-1:0];
    end

endmodule

// File: rtl/bus_mux_arb.sv
// N-channel bus mux with fixed-select or round-robin arbitration and a
// registered valid/ready output stage.
// Ports: clk, rst_n (sync, active-low); rr_en, sel select mode/channel;
// in_valid/in_data/in_ready per-channel input handshake;
// out_valid/out_data/out_grant/out_ready output handshake.
module bus_mux_arb
    import bus_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int NCH   = BUS_NCH,
    parameter int SW    = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rr_en,
    input  logic [SW-1:0]      sel,
    input  logic [NCH-1:0]     in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]     in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_grant,
    input  logic               out_ready
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SW-1:0]    grant_q, grant_d;
    logic [SW-1:0]    last_q, last_d;

    logic             load;
    logic             rr_found;
    logic [SW-1:0]    rr_idx;
    logic             cand_ok;
    logic [SW-1:0]    cand;
    logic [WIDTH-1:0] cand_data;
    logic             xfer;

    rr_pick #(
        .NCH (NCH),
        .SW  (SW)
    ) u_rr_pick (
        .valid (in_valid),
        .last  (last_q),
        .found (rr_found),
        .idx   (rr_idx)
    );

    assign load = !valid_q || out_ready;

    always_comb begin
        cand_ok = 1'b0;
        cand    = '0;
        if (rr_en) begin
            cand_ok = rr_found;
            cand    = rr_idx;
        end else begin
            // Out-of-range select codes name no channel.
            cand_ok = (int'(sel) < NCH);
            cand    = sel;
        end
    end

    always_comb begin
        in_ready  = '0;
        cand_data = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = rst_n && load && cand_ok && (cand == SW'(i));
            if (cand == SW'(i)) begin
                cand_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(in_ready & in_valid);

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (xfer) begin
            valid_d = 1'b1;
            data_d  = cand_data;
            grant_d = cand;
            last_d  = cand;
        end else if (load) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            last_q  <= SW'(NCH - 1);
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_grant = grant_q;

endmodule
